// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - single-port data memory with fixed wait-state stall handshake
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
module data_memory_ctrl #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        MisalignErr
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t        state, next_state;
   logic [3:0]    cnt, next_cnt;
   logic [31:0]   lat_addr, lat_wdata;
   logic          lat_we;
   logic [31:0]   mem [DEPTH_WORDS];

   logic          req, load, complete, acc_we, misalign, do_write;
   logic [31:0]   acc_addr, acc_wdata;
   logic [AW-1:0] acc_idx;
   logic          unused_bits;

   // Outputs are gated by reset so a held request cannot leak through during reset.
   always_comb begin
      req        = MemRead | MemWrite;
      next_state = state;
      next_cnt   = cnt;
      Stall      = 1'b0;
      load       = 1'b0;
      complete   = 1'b0;
      acc_addr   = lat_addr;
      acc_wdata  = lat_wdata;
      acc_we     = lat_we;
      if (reset) begin
         case (state)
            IDLE: begin
               if (req) begin
                  if (WAIT_STATES > 0) begin
                     Stall      = 1'b1;
                     load       = 1'b1;
                     next_cnt   = CNT_INIT;
                     next_state = WAIT;
                  end else begin
                     complete  = 1'b1;
                     acc_addr  = Addr;
                     acc_wdata = WriteData;
                     acc_we    = MemWrite;
                  end
               end
            end
            WAIT: begin
               if (cnt != 4'd0) begin
                  Stall    = 1'b1;
                  next_cnt = cnt - 4'd1;
               end else begin
                  complete   = 1'b1;
                  next_state = IDLE;
               end
            end
         endcase
      end
      acc_idx = acc_addr[AW+1:2];
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign = (acc_addr[1:0] != 2'b00);
`else
      misalign = 1'b0;
`endif
      do_write = complete & acc_we & ~misalign;
      ReadData = (complete & ~acc_we & ~misalign) ? mem[acc_idx] : 32'd0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         lat_addr  <= 32'd0;
         lat_wdata <= 32'd0;
         lat_we    <= 1'b0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
         if (load) begin
            lat_addr  <= Addr;
            lat_wdata <= WriteData;
            lat_we    <= MemWrite;
         end
      end
   end

   // Array is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (do_write)
         mem[acc_idx] <= acc_wdata;
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   logic merr;
   always_ff @(posedge clk) begin
      if (!reset)
         merr <= 1'b0;
      else if (complete & misalign)
         merr <= 1'b1;
   end
   assign MisalignErr = merr;
`else
   assign MisalignErr = 1'b0;
`endif

   assign unused_bits = ^{Addr[31:AW+2], lat_addr[31:AW+2], Addr[1:0], lat_addr[1:0]};

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - scoreboard bench for data_memory_ctrl (WAIT_STATES=2 and 0 instances)
module tb_data_memory_ctrl;

   localparam int WS = 2;

   typedef struct {
      int          cyc;
      bit          which;
      logic        stall;
      logic [31:0] rd;
      logic        merr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_a, wr_a, rd_b, wr_b;
   logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
   logic [31:0] rdata_a, rdata_b;
   logic        stall_a, stall_b, merr_a, merr_b;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic exp_merr = 1'b0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_memory_ctrl #(.DEPTH_WORDS(64), .WAIT_STATES(WS)) dut (
      .clk(clk), .reset(reset), .MemRead(rd_a), .MemWrite(wr_a), .Addr(addr_a),
      .WriteData(wdata_a), .ReadData(rdata_a), .Stall(stall_a), .MisalignErr(merr_a));

   data_memory_ctrl #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(reset), .MemRead(rd_b), .MemWrite(wr_b), .Addr(addr_b),
      .WriteData(wdata_b), .ReadData(rdata_b), .Stall(stall_b), .MisalignErr(merr_b));

   function automatic void push(input bit which, input logic stall, input logic [31:0] rd, input logic merr);
      exp_t e;
      e.cyc = cyc; e.which = which; e.stall = stall; e.rd = rd; e.merr = merr;
      sb.push_back(e);
   endfunction

   function automatic void chk(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, c, act, req);
      end
   endfunction

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         if (e.cyc < cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL missed_sample cyc=%0d actual=none required=sample", e.cyc);
         end else if (e.which == 1'b0) begin
            chk("stall", e.cyc, {31'd0, stall_a}, {31'd0, e.stall});
            chk("rdata", e.cyc, rdata_a, e.rd);
            chk("merr",  e.cyc, {31'd0, merr_a}, {31'd0, e.merr});
         end else begin
            chk("ws0_stall", e.cyc, {31'd0, stall_b}, {31'd0, e.stall});
            chk("ws0_rdata", e.cyc, rdata_b, e.rd);
            chk("ws0_merr",  e.cyc, {31'd0, merr_b}, {31'd0, e.merr});
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      rd_a = 1'b0; wr_a = 1'b0;
      for (int i = 0; i < n; i++) begin
         push(1'b0, 1'b0, 32'd0, exp_merr);
         step();
      end
   endtask

   // One full access on the WAIT_STATES=2 instance: WS stall cycles then a completion cycle.
   task automatic access(input logic re, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd);
      rd_a = re; wr_a = we; addr_a = a; wdata_a = wd;
      for (int i = 0; i <= WS; i++) begin
         push(1'b0, (i < WS), (i == WS) ? exp_rd : 32'd0, exp_merr);
         step();
      end
`ifdef DMEM_MISALIGN_TRAP_EN
      if (a[1:0] != 2'b00) exp_merr = 1'b1;
`endif
   endtask

   task automatic access0(input logic re, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd);
      rd_b = re; wr_b = we; addr_b = a; wdata_b = wd;
      push(1'b1, 1'b0, exp_rd, 1'b0);
      step();
      rd_b = 1'b0; wr_b = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      rd_a = 1'b0; wr_a = 1'b1; addr_a = 32'h10; wdata_a = 32'h1;
      rd_b = 1'b1; wr_b = 1'b0; addr_b = 32'h8;  wdata_b = 32'h0;
      step();
      // Requests held during reset must see no stall and no read data.
      for (int i = 0; i < 2; i++) begin
         push(1'b0, 1'b0, 32'd0, 1'b0);
         push(1'b1, 1'b0, 32'd0, 1'b0);
         step();
      end
      reset = 1'b1;
      rd_b = 1'b0;
      idle(1);

      access(1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'd0);
      access(1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF);
      idle(1);
      access(1'b0, 1'b1, 32'h04,  32'h11111111, 32'd0);
      access(1'b0, 1'b1, 32'h104, 32'h22222222, 32'd0);
      access(1'b1, 1'b0, 32'h04,  32'h0,        32'h22222222);
      access(1'b1, 1'b1, 32'h20,  32'h5A5A5A5A, 32'd0);
      access(1'b1, 1'b0, 32'h20,  32'h0,        32'h5A5A5A5A);
      access(1'b0, 1'b1, 32'hFC,  32'hA5A5F00F, 32'd0);
      access(1'b1, 1'b0, 32'h1FC, 32'h0,        32'hA5A5F00F);

      // Reset in the first WAIT cycle drops the pending store.
      access(1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 32'd0);
      wr_a = 1'b1; addr_a = 32'h30; wdata_a = 32'h12345678;
      push(1'b0, 1'b1, 32'd0, 1'b0);
      step();
      reset = 1'b0;
      push(1'b0, 1'b0, 32'd0, 1'b0);
      step();
      reset = 1'b1;
      idle(1);
      access(1'b1, 1'b0, 32'h30, 32'h0, 32'hCAFEF00D);

      access(1'b0, 1'b1, 32'h40, 32'h13579BDF, 32'd0);
      access(1'b0, 1'b1, 32'h42, 32'h0BADF00D, 32'd0);
      idle(1);
`ifdef DMEM_MISALIGN_TRAP_EN
      access(1'b1, 1'b0, 32'h40, 32'h0, 32'h13579BDF);
      access(1'b1, 1'b0, 32'h41, 32'h0, 32'd0);
`else
      access(1'b1, 1'b0, 32'h40, 32'h0, 32'h0BADF00D);
`endif
      reset = 1'b0;
      push(1'b0, 1'b0, 32'd0, exp_merr);
      step();
      reset = 1'b1;
      exp_merr = 1'b0;
      idle(1);

      access0(1'b0, 1'b1, 32'h8,   32'h00000077, 32'd0);
      access0(1'b1, 1'b0, 32'h8,   32'h0,        32'h00000077);
      access0(1'b0, 1'b1, 32'h108, 32'h00000099, 32'd0);
      access0(1'b1, 1'b0, 32'h8,   32'h0,        32'h00000099);
      access0(1'b1, 1'b1, 32'h0C,  32'h0000ABCD, 32'd0);
      access0(1'b1, 1'b0, 32'h0C,  32'h0,        32'h0000ABCD);
      push(1'b1, 1'b0, 32'd0, 1'b0);
      step();

      for (int i = 0; i < 10 && sb.size() > 0; i++) step();
      if (sb.size() > 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain actual=%0d required=0 pending", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
